// File: rtl/spi_master.sv
// SPI bus master: one DW-bit word per frame on a valid/ready interface, MSB first,
// with scl generated from clk by a programmable half-period divider.
module spi_master #(
    parameter int CPOL     = 1,
    parameter int CPHA     = 1,
    parameter int DW       = 8,
    parameter int CLK_DIV  = 4,
    parameter int SS_SETUP = 2,
    parameter int SS_HOLD  = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          tx_valid,
    output logic          tx_ready,
    input  logic [DW-1:0] tx_data,
    output logic          rx_valid,
    output logic [DW-1:0] rx_data,
    output logic          busy,
    output logic          scl,
    output logic          ss,
    output logic          mosi,
    input  logic          miso
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam int EW     = $clog2(2 * DW + 1);
    localparam int HW     = $clog2(CLK_DIV);
    localparam int SS_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
    localparam int CW     = $clog2(SS_MAX + 1);

    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW - 1);
    localparam logic [HW-1:0] HALF_TC   = HW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_TC  = CW'(SS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_TC   = CW'(SS_HOLD - 1);
    localparam logic          SCL_IDLE  = (CPOL != 0);

    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [HW-1:0] half_reg, half_next;
    logic [EW-1:0] edge_reg, edge_next;
    logic [DW-1:0] tx_sr_reg, tx_sr_next;
    logic [DW-1:0] rx_sr_reg, rx_sr_next;
    logic [DW-1:0] rx_data_reg, rx_data_next;
    logic          scl_reg, scl_next;
    logic          ss_reg, ss_next;
    logic          mosi_reg, mosi_next;
    logic          tx_ready_reg, tx_ready_next;
    logic          rx_valid_reg, rx_valid_next;
    logic          busy_reg, busy_next;

    logic accept;
    logic half_tc;
    logic is_lead;
    logic last_edge;
    logic sample_edge;
    logic shift_edge;

    assign accept    = tx_valid && tx_ready_reg;
    assign half_tc   = (half_reg == HALF_TC);
    // Edge numbering starts at 1, so an even count before the toggle means a leading edge.
    assign is_lead   = ~edge_reg[0];
    assign last_edge = (edge_reg == LAST_EDGE);

    assign sample_edge = (CPHA == 0) ? is_lead : ~is_lead;
    assign shift_edge  = ~sample_edge && !((CPHA == 0) && last_edge);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        half_next     = half_reg;
        edge_next     = edge_reg;
        tx_sr_next    = tx_sr_reg;
        rx_sr_next    = rx_sr_reg;
        rx_data_next  = rx_data_reg;
        scl_next      = scl_reg;
        ss_next       = ss_reg;
        mosi_next     = mosi_reg;
        rx_valid_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                ss_next   = 1'b1;
                scl_next  = SCL_IDLE;
                mosi_next = 1'b0;
                if (accept) begin
                    state_next = ST_SETUP;
                    ss_next    = 1'b0;
                    cnt_next   = '0;
                    half_next  = '0;
                    edge_next  = '0;
                    // With CPHA=0 the MSB must already be on mosi before the first edge.
                    if (CPHA == 0) begin
                        mosi_next  = tx_data[DW-1];
                        tx_sr_next = tx_data << 1;
                    end else begin
                        mosi_next  = mosi_reg;
                        tx_sr_next = tx_data;
                    end
                end
            end

            ST_SETUP: begin
                if (cnt_reg == SETUP_TC) begin
                    state_next = ST_SHIFT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (half_tc) begin
                    half_next = '0;
                    scl_next  = ~scl_reg;
                    edge_next = edge_reg + 1'b1;
                    if (sample_edge) begin
                        rx_sr_next = {rx_sr_reg[DW-2:0], miso};
                    end
                    if (shift_edge) begin
                        mosi_next  = tx_sr_reg[DW-1];
                        tx_sr_next = tx_sr_reg << 1;
                    end
                    if (last_edge) begin
                        state_next = ST_HOLD;
                        cnt_next   = '0;
                    end
                end else begin
                    half_next = half_reg + 1'b1;
                end
            end

            ST_HOLD: begin
                if (cnt_reg == HOLD_TC) begin
                    state_next    = ST_GAP;
                    cnt_next      = '0;
                    ss_next       = 1'b1;
                    rx_valid_next = 1'b1;
                    rx_data_next  = rx_sr_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_GAP: begin
                state_next = ST_IDLE;
                mosi_next  = 1'b0;
            end

            default: begin
                state_next = ST_IDLE;
                ss_next    = 1'b1;
                scl_next   = SCL_IDLE;
                mosi_next  = 1'b0;
            end
        endcase

        tx_ready_next = (state_next == ST_IDLE);
        busy_next     = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            half_reg     <= '0;
            edge_reg     <= '0;
            tx_sr_reg    <= '0;
            rx_sr_reg    <= '0;
            rx_data_reg  <= '0;
            scl_reg      <= SCL_IDLE;
            ss_reg       <= 1'b1;
            mosi_reg     <= 1'b0;
            tx_ready_reg <= 1'b0;
            rx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            half_reg     <= half_next;
            edge_reg     <= edge_next;
            tx_sr_reg    <= tx_sr_next;
            rx_sr_reg    <= rx_sr_next;
            rx_data_reg  <= rx_data_next;
            scl_reg      <= scl_next;
            ss_reg       <= ss_next;
            mosi_reg     <= mosi_next;
            tx_ready_reg <= tx_ready_next;
            rx_valid_reg <= rx_valid_next;
            busy_reg     <= busy_next;
        end
    end

    assign tx_ready = tx_ready_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_data  = rx_data_reg;
    assign busy     = busy_reg;
    assign scl      = scl_reg;
    assign ss       = ss_reg;
    assign mosi     = mosi_reg;

endmodule
